// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
// Decodes host command frames arriving byte-by-byte from the SPI slave shifter.
// Per axis (pitch, yaw) it atomically updates PWM duty and H-bridge direction,
// issues encoder count clears, and returns a snapshotted 16-bit count as two
// transmit bytes.
// Optional feature: define CMD_WDOG_EN to enable the command watchdog, which
// stops both motors if no SET/GET/NOP command completes within WDOG_CYCLES
// clocks.
module spi_cmd_sequencer #(
  parameter int PWM_W       = 10,
  parameter int CNT_W       = 16,
  parameter int DUTY_MAX    = 1023,
  parameter int WDOG_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             frame_end,
  output logic [7:0]       tx_byte,
  output logic             tx_load,
  input  logic [CNT_W-1:0] pitch_count,
  input  logic [CNT_W-1:0] yaw_count,
  output logic [PWM_W-1:0] pitch_duty,
  output logic             pitch_dira,
  output logic             pitch_dirb,
  output logic [PWM_W-1:0] yaw_duty,
  output logic             yaw_dira,
  output logic             yaw_dirb,
  output logic [1:0]       cnt_clear,
  output logic             cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_DIR,
    S_SET_HI,
    S_SET_LO,
    S_GET_HI,
    S_GET_LO
  } state_t;

  localparam logic [15:0]      DUTY_MAX_16 = 16'(DUTY_MAX);
  localparam logic [PWM_W-1:0] DUTY_MAX_W  = PWM_W'(DUTY_MAX);

  // Parameter sanity guards; these blocks are empty and only exist so an
  // illegal override shows up as an oddly named scope in the hierarchy.
  if (CNT_W < 9 || CNT_W > 16) begin : g_cnt_w_out_of_range
  end
  if (WDOG_CYCLES < 1) begin : g_wdog_cycles_out_of_range
  end

  state_t r_state, w_state_next;

  // Command context and argument shadows
  logic             r_axis, w_axis_next;        // 0 = pitch, 1 = yaw
  logic [1:0]       r_dir_sh, w_dir_sh_next;
  logic [7:0]       r_hi_sh, w_hi_sh_next;
  logic [CNT_W-1:0] r_snap, w_snap_next;

  // Registered outputs
  logic [7:0]       r_tx_byte, w_tx_byte_next;
  logic             r_tx_load, w_tx_load_next;
  logic [PWM_W-1:0] r_pitch_duty, w_pitch_duty_next;
  logic             r_pitch_dira, w_pitch_dira_next;
  logic             r_pitch_dirb, w_pitch_dirb_next;
  logic [PWM_W-1:0] r_yaw_duty, w_yaw_duty_next;
  logic             r_yaw_dira, w_yaw_dira_next;
  logic             r_yaw_dirb, w_yaw_dirb_next;
  logic [1:0]       r_cnt_clear, w_cnt_clear_next;
  logic             r_cmd_err, w_cmd_err_next;

  // Datapath helpers
  logic [15:0]      w_duty_raw;
  logic [PWM_W-1:0] w_duty_clamped;
  logic [CNT_W-1:0] w_count_sel;
  logic [7:0]       w_count_hi;
  logic             w_rx_take;

  // A byte is only acted upon when no frame_end accompanies it
  assign w_rx_take      = rx_valid && !frame_end;
  assign w_duty_raw     = {r_hi_sh, rx_byte};
  assign w_duty_clamped = (w_duty_raw > DUTY_MAX_16) ? DUTY_MAX_W : w_duty_raw[PWM_W-1:0];
  // Command bit 5 selects the axis (0x1x pitch, 0x2x yaw)
  assign w_count_sel    = rx_byte[5] ? yaw_count : pitch_count;
  assign w_count_hi     = 8'(w_count_sel >> 8);

`ifdef CMD_WDOG_EN
  localparam int              WDOG_W   = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_fired;
  logic              w_cmd_done;
  logic              w_wdog_trip;

  // A SET, GET or NOP command finishes on these bytes
  assign w_cmd_done = w_rx_take &&
                      ((r_state == S_IDLE && rx_byte == 8'h00) ||
                       r_state == S_SET_LO || r_state == S_GET_LO);
  assign w_wdog_trip = (r_wdog_cnt == WDOG_LIM) && !r_wdog_fired && !w_cmd_done &&
                       ((r_pitch_duty != '0) || (r_yaw_duty != '0));

  // Watchdog counter: reload on completed command, saturate at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog_cnt   <= '0;
      r_wdog_fired <= 1'b0;
    end else if (w_cmd_done) begin
      r_wdog_cnt   <= '0;
      r_wdog_fired <= 1'b0;
    end else begin
      if (r_wdog_cnt != WDOG_LIM) r_wdog_cnt <= r_wdog_cnt + 1'b1;
      if (w_wdog_trip) r_wdog_fired <= 1'b1;
    end
  end
`else
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and next-output decode for every received byte / frame end
  always_comb begin
    w_state_next      = r_state;
    w_axis_next       = r_axis;
    w_dir_sh_next     = r_dir_sh;
    w_hi_sh_next      = r_hi_sh;
    w_snap_next       = r_snap;
    w_tx_byte_next    = r_tx_byte;
    w_tx_load_next    = 1'b0;
    w_pitch_duty_next = r_pitch_duty;
    w_pitch_dira_next = r_pitch_dira;
    w_pitch_dirb_next = r_pitch_dirb;
    w_yaw_duty_next   = r_yaw_duty;
    w_yaw_dira_next   = r_yaw_dira;
    w_yaw_dirb_next   = r_yaw_dirb;
    w_cnt_clear_next  = 2'b00;
    w_cmd_err_next    = 1'b0;

    if (frame_end) begin
      // Chip-select released mid-command: drop the partial command
      if (r_state != S_IDLE) begin
        w_state_next  = S_IDLE;
        w_dir_sh_next = '0;
        w_hi_sh_next  = '0;
        w_snap_next   = '0;
        if (r_state == S_SET_DIR || r_state == S_SET_HI || r_state == S_SET_LO)
          w_cmd_err_next = 1'b1;
      end
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          case (rx_byte)
            8'hFF: begin
              w_pitch_duty_next = '0;
              w_pitch_dira_next = 1'b0;
              w_pitch_dirb_next = 1'b0;
              w_yaw_duty_next   = '0;
              w_yaw_dira_next   = 1'b0;
              w_yaw_dirb_next   = 1'b0;
              w_cnt_clear_next  = 2'b11;
              w_dir_sh_next     = '0;
              w_hi_sh_next      = '0;
              w_snap_next       = '0;
            end
            8'h11, 8'h21: begin
              w_axis_next  = rx_byte[5];
              w_state_next = S_SET_DIR;
            end
            8'h12, 8'h22: begin
              // Snapshot now so both response bytes are coherent
              w_axis_next    = rx_byte[5];
              w_snap_next    = w_count_sel;
              w_tx_byte_next = w_count_hi;
              w_tx_load_next = 1'b1;
              w_state_next   = S_GET_HI;
            end
            8'h13:   w_cnt_clear_next = 2'b01;
            8'h23:   w_cnt_clear_next = 2'b10;
            8'h00:   ;
            default: w_cmd_err_next = 1'b1;
          endcase
        end
        S_SET_DIR: begin
          w_dir_sh_next = rx_byte[1:0];
          w_state_next  = S_SET_HI;
        end
        S_SET_HI: begin
          w_hi_sh_next = rx_byte;
          w_state_next = S_SET_LO;
        end
        S_SET_LO: begin
          // Commit duty and direction together
          if (r_axis) begin
            w_yaw_duty_next   = w_duty_clamped;
            w_yaw_dira_next   = (r_dir_sh == 2'b01);
            w_yaw_dirb_next   = (r_dir_sh == 2'b10);
          end else begin
            w_pitch_duty_next = w_duty_clamped;
            w_pitch_dira_next = (r_dir_sh == 2'b01);
            w_pitch_dirb_next = (r_dir_sh == 2'b10);
          end
          w_dir_sh_next = '0;
          w_hi_sh_next  = '0;
          w_state_next  = S_IDLE;
        end
        S_GET_HI: begin
          w_tx_byte_next = r_snap[7:0];
          w_tx_load_next = 1'b1;
          w_state_next   = S_GET_LO;
        end
        S_GET_LO: begin
          w_tx_byte_next = 8'h00;
          w_tx_load_next = 1'b1;
          w_state_next   = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end

`ifdef CMD_WDOG_EN
    if (w_wdog_trip) begin
      w_pitch_duty_next = '0;
      w_pitch_dira_next = 1'b0;
      w_pitch_dirb_next = 1'b0;
      w_yaw_duty_next   = '0;
      w_yaw_dira_next   = 1'b0;
      w_yaw_dirb_next   = 1'b0;
      w_cmd_err_next    = 1'b1;
    end
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_axis       <= 1'b0;
      r_dir_sh     <= '0;
      r_hi_sh      <= '0;
      r_snap       <= '0;
      r_tx_byte    <= '0;
      r_tx_load    <= 1'b0;
      r_pitch_duty <= '0;
      r_pitch_dira <= 1'b0;
      r_pitch_dirb <= 1'b0;
      r_yaw_duty   <= '0;
      r_yaw_dira   <= 1'b0;
      r_yaw_dirb   <= 1'b0;
      r_cnt_clear  <= 2'b00;
      r_cmd_err    <= 1'b0;
    end else begin
      r_axis       <= w_axis_next;
      r_dir_sh     <= w_dir_sh_next;
      r_hi_sh      <= w_hi_sh_next;
      r_snap       <= w_snap_next;
      r_tx_byte    <= w_tx_byte_next;
      r_tx_load    <= w_tx_load_next;
      r_pitch_duty <= w_pitch_duty_next;
      r_pitch_dira <= w_pitch_dira_next;
      r_pitch_dirb <= w_pitch_dirb_next;
      r_yaw_duty   <= w_yaw_duty_next;
      r_yaw_dira   <= w_yaw_dira_next;
      r_yaw_dirb   <= w_yaw_dirb_next;
      r_cnt_clear  <= w_cnt_clear_next;
      r_cmd_err    <= w_cmd_err_next;
    end
  end

  assign tx_byte    = r_tx_byte;
  assign tx_load    = r_tx_load;
  assign pitch_duty = r_pitch_duty;
  assign pitch_dira = r_pitch_dira;
  assign pitch_dirb = r_pitch_dirb;
  assign yaw_duty   = r_yaw_duty;
  assign yaw_dira   = r_yaw_dira;
  assign yaw_dirb   = r_yaw_dirb;
  assign cnt_clear  = r_cnt_clear;
  assign cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Testbench for spi_cmd_sequencer (default build, watchdog disabled).
// Directed scenarios from the command set plus randomized frames checked
// against a frame-level reference model.
module tb_spi_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        frame_end = 1'b0;
  logic [15:0] pitch_count = 16'h0000;
  logic [15:0] yaw_count = 16'h0000;
  logic [7:0]  tx_byte;
  logic        tx_load;
  logic [9:0]  pitch_duty, yaw_duty;
  logic        pitch_dira, pitch_dirb, yaw_dira, yaw_dirb;
  logic [1:0]  cnt_clear;
  logic        cmd_err;

  int checks = 0;
  int failures = 0;

  // Reference model: drive state, last tx byte, bytes of the frame's open command
  logic [9:0]  m_pduty, m_yduty;
  logic        m_pa, m_pb, m_ya, m_yb;
  logic [7:0]  m_tx;
  logic [15:0] m_snap;
  logic [7:0]  m_fq[$];
  logic        e_load;
  logic [1:0]  e_cc;
  logic        e_err;

  spi_cmd_sequencer dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_end(frame_end), .tx_byte(tx_byte), .tx_load(tx_load),
    .pitch_count(pitch_count), .yaw_count(yaw_count),
    .pitch_duty(pitch_duty), .pitch_dira(pitch_dira), .pitch_dirb(pitch_dirb),
    .yaw_duty(yaw_duty), .yaw_dira(yaw_dira), .yaw_dirb(yaw_dirb),
    .cnt_clear(cnt_clear), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pduty = '0; m_yduty = '0;
    m_pa = 0; m_pb = 0; m_ya = 0; m_yb = 0;
    m_tx = 8'h00; m_snap = '0;
    m_fq.delete();
    e_load = 0; e_cc = 2'b00; e_err = 0;
  endtask

  // One transaction: present inputs for one clock, update the model, return
  // at the following falling edge where the registered response is visible.
  task automatic drive(input logic rv, input logic [7:0] b, input logic fe,
                       input logic [15:0] pc, input logic [15:0] yc);
    logic [7:0] cmd;
    int d;
    logic [1:0] dir;
    @(negedge clk);
    rx_valid = rv; rx_byte = b; frame_end = fe;
    pitch_count = pc; yaw_count = yc;
    e_load = 0; e_cc = 2'b00; e_err = 0;
    if (fe) begin
      if (m_fq.size() > 0 && (m_fq[0] == 8'h11 || m_fq[0] == 8'h21)) e_err = 1;
      m_fq.delete();
    end else if (rv) begin
      m_fq.push_back(b);
      cmd = m_fq[0];
      case (cmd)
        8'hFF: begin
          m_pduty = '0; m_yduty = '0;
          m_pa = 0; m_pb = 0; m_ya = 0; m_yb = 0;
          e_cc = 2'b11;
          m_fq.delete();
        end
        8'h11, 8'h21: begin
          if (m_fq.size() == 4) begin
            d = m_fq[2] * 256 + m_fq[3];
            if (d > 1023) d = 1023;
            dir = m_fq[1][1:0];
            if (cmd == 8'h11) begin
              m_pduty = 10'(d); m_pa = (dir == 2'd1); m_pb = (dir == 2'd2);
            end else begin
              m_yduty = 10'(d); m_ya = (dir == 2'd1); m_yb = (dir == 2'd2);
            end
            m_fq.delete();
          end
        end
        8'h12, 8'h22: begin
          e_load = 1;
          if (m_fq.size() == 1) begin
            m_snap = (cmd == 8'h12) ? pc : yc;
            m_tx = m_snap[15:8];
          end else if (m_fq.size() == 2) begin
            m_tx = m_snap[7:0];
          end else begin
            m_tx = 8'h00;
            m_fq.delete();
          end
        end
        8'h13: begin e_cc = 2'b01; m_fq.delete(); end
        8'h23: begin e_cc = 2'b10; m_fq.delete(); end
        8'h00: m_fq.delete();
        default: begin e_err = 1; m_fq.delete(); end
      endcase
    end
    @(negedge clk);
    rx_valid = 0; frame_end = 0;
    $display("xfer rv=%0d byte=%02h fe=%0d -> tx_load=%0d tx=%02h cc=%0d err=%0d p=%03h/%0d%0d y=%03h/%0d%0d",
             rv, b, fe, tx_load, tx_byte, cnt_clear, cmd_err,
             pitch_duty, pitch_dira, pitch_dirb, yaw_duty, yaw_dira, yaw_dirb);
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_byte, tx_load, pitch_duty, pitch_dira, pitch_dirb, yaw_duty, yaw_dira, yaw_dirb, cnt_clear, cmd_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got tx=%02h ld=%0d p=%03h y=%03h dirs=%0d%0d%0d%0d cc=%0d err=%0d want all 0",
               tx_byte, tx_load, pitch_duty, yaw_duty, pitch_dira, pitch_dirb, yaw_dira, yaw_dirb, cnt_clear, cmd_err);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_load, pitch_duty, yaw_duty, cnt_clear, cmd_err} !== '0) begin
      failures++;
      $display("FAIL post_reset_idle: got ld=%0d p=%03h y=%03h cc=%0d err=%0d want 0", tx_load, pitch_duty, yaw_duty, cnt_clear, cmd_err);
    end
  endtask

  task automatic test_set_drive();
    logic [7:0] bytes[4];
    bytes = '{8'h11, 8'h01, 8'h02, 8'h40};
    for (int i = 0; i < 3; i++) begin
      drive(1, bytes[i], 0, 16'h0, 16'h0);
      checks++;
      if ({pitch_duty, pitch_dira, pitch_dirb} !== {10'h000, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL set_partial_%0d: got duty=%03h a=%0d b=%0d want 000 0 0", i, pitch_duty, pitch_dira, pitch_dirb);
      end
    end
    drive(1, bytes[3], 0, 16'h0, 16'h0);
    checks++;
    if ({pitch_duty, pitch_dira, pitch_dirb} !== {10'h240, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL set_pitch: got duty=%03h a=%0d b=%0d want 240 1 0", pitch_duty, pitch_dira, pitch_dirb);
    end
    drive(0, 8'h00, 1, 16'h0, 16'h0);
  endtask

  task automatic test_get_count();
    drive(1, 8'h12, 0, 16'h1234, 16'h0);
    checks++;
    if ({tx_load, tx_byte} !== {1'b1, 8'h12}) begin
      failures++;
      $display("FAIL get_hi: got ld=%0d tx=%02h want 1 12", tx_load, tx_byte);
    end
    idle();
    checks++;
    if ({tx_load, tx_byte} !== {1'b0, 8'h12}) begin
      failures++;
      $display("FAIL get_hi_pulse: got ld=%0d tx=%02h want 0 12", tx_load, tx_byte);
    end
    drive(1, 8'hA5, 0, 16'h5678, 16'h0);
    checks++;
    if ({tx_load, tx_byte} !== {1'b1, 8'h34}) begin
      failures++;
      $display("FAIL get_lo_snapshot: got ld=%0d tx=%02h want 1 34", tx_load, tx_byte);
    end
    drive(1, 8'h5A, 0, 16'h5678, 16'h0);
    checks++;
    if ({tx_load, tx_byte} !== {1'b1, 8'h00}) begin
      failures++;
      $display("FAIL get_trailer: got ld=%0d tx=%02h want 1 00", tx_load, tx_byte);
    end
    drive(0, 8'h00, 1, 16'h5678, 16'h0);
  endtask

  task automatic test_clamp();
    logic [7:0] bytes[4];
    bytes = '{8'h21, 8'h02, 8'hFF, 8'hFF};
    for (int i = 0; i < 4; i++) drive(1, bytes[i], 0, 16'h0, 16'h0);
    checks++;
    if ({yaw_duty, yaw_dira, yaw_dirb, pitch_duty} !== {10'd1023, 1'b0, 1'b1, 10'h240}) begin
      failures++;
      $display("FAIL yaw_clamp: got y=%0d a=%0d b=%0d p=%03h want 1023 0 1 240", yaw_duty, yaw_dira, yaw_dirb, pitch_duty);
    end
    drive(0, 8'h00, 1, 16'h0, 16'h0);
  endtask

  task automatic test_abort();
    drive(1, 8'h11, 0, 16'h0, 16'h0);
    drive(1, 8'h01, 0, 16'h0, 16'h0);
    drive(0, 8'h00, 1, 16'h0, 16'h0);
    checks++;
    if ({cmd_err, pitch_duty, pitch_dira, pitch_dirb} !== {1'b1, 10'h240, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL set_abort: got err=%0d duty=%03h a=%0d b=%0d want 1 240 1 0", cmd_err, pitch_duty, pitch_dira, pitch_dirb);
    end
    drive(1, 8'h12, 0, 16'hBEEF, 16'h0);
    checks++;
    if ({tx_load, tx_byte, cmd_err} !== {1'b1, 8'hBE, 1'b0}) begin
      failures++;
      $display("FAIL cmd_after_abort: got ld=%0d tx=%02h err=%0d want 1 be 0", tx_load, tx_byte, cmd_err);
    end
    drive(0, 8'h00, 1, 16'h0, 16'h0);
    checks++;
    if ({cmd_err, tx_load} !== 2'b00) begin
      failures++;
      $display("FAIL get_abort: got err=%0d ld=%0d want 0 0", cmd_err, tx_load);
    end
  endtask

  task automatic test_collision();
    // Byte coinciding with frame_end is ignored, even in IDLE
    drive(1, 8'h13, 1, 16'h0, 16'h0);
    checks++;
    if ({cnt_clear, cmd_err} !== 3'b000) begin
      failures++;
      $display("FAIL collide_idle: got cc=%0d err=%0d want 0 0", cnt_clear, cmd_err);
    end
    drive(1, 8'h21, 0, 16'h0, 16'h0);
    drive(1, 8'h01, 1, 16'h0, 16'h0);
    checks++;
    if ({cmd_err, yaw_duty} !== {1'b1, 10'd1023}) begin
      failures++;
      $display("FAIL collide_set: got err=%0d y=%0d want 1 1023", cmd_err, yaw_duty);
    end
    drive(1, 8'h23, 0, 16'h0, 16'h0);
    checks++;
    if ({cnt_clear, cmd_err} !== 3'b100) begin
      failures++;
      $display("FAIL clear_yaw: got cc=%0d err=%0d want 2 0", cnt_clear, cmd_err);
    end
    drive(1, 8'h13, 0, 16'h0, 16'h0);
    checks++;
    if (cnt_clear !== 2'b01) begin
      failures++;
      $display("FAIL clear_pitch: got cc=%0d want 1", cnt_clear);
    end
  endtask

  task automatic test_global_reset();
    drive(1, 8'hFF, 0, 16'h0, 16'h0);
    checks++;
    if ({pitch_duty, yaw_duty, pitch_dira, pitch_dirb, yaw_dira, yaw_dirb, cnt_clear} !== {24'h0, 2'b11}) begin
      failures++;
      $display("FAIL global_reset: got p=%03h y=%03h dirs=%0d%0d%0d%0d cc=%0d want 0 0 0000 3",
               pitch_duty, yaw_duty, pitch_dira, pitch_dirb, yaw_dira, yaw_dirb, cnt_clear);
    end
    idle();
    checks++;
    if (cnt_clear !== 2'b00) begin
      failures++;
      $display("FAIL global_reset_pulse: got cc=%0d want 0", cnt_clear);
    end
    drive(1, 8'h7E, 0, 16'h0, 16'h0);
    checks++;
    if (cmd_err !== 1'b1) begin
      failures++;
      $display("FAIL bad_cmd: got err=%0d want 1", cmd_err);
    end
    idle();
    checks++;
    if (cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL bad_cmd_pulse: got err=%0d want 0", cmd_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmds[10];
    logic [7:0] c, b;
    int nbytes, sent;
    cmds = '{8'h00, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23, 8'hFF, 8'h7E, 8'hC3};
    model_reset();
    drive(1, 8'hFF, 0, 16'h0, 16'h0);   // align DUT and model
    drive(0, 8'h00, 1, 16'h0, 16'h0);
    for (int f = 0; f < 80; f++) begin
      c = cmds[$urandom_range(0, 9)];
      nbytes = (c == 8'h11 || c == 8'h21) ? 4 : (c == 8'h12 || c == 8'h22) ? 3 : 1;
      sent = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nbytes) : nbytes;
      for (int i = 0; i < sent; i++) begin
        b = 8'($urandom);
        if (i == 0) b = c;
        else if (i == 2 && $urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 4));
        drive(1, b, 0, 16'($urandom), 16'($urandom));
        checks++;
        if ({pitch_duty, pitch_dira, pitch_dirb, yaw_duty, yaw_dira, yaw_dirb} !== {m_pduty, m_pa, m_pb, m_yduty, m_ya, m_yb}) begin
          failures++;
          $display("FAIL rand_drive f%0d b%0d: got p=%03h %0d%0d y=%03h %0d%0d want p=%03h %0d%0d y=%03h %0d%0d",
                   f, i, pitch_duty, pitch_dira, pitch_dirb, yaw_duty, yaw_dira, yaw_dirb, m_pduty, m_pa, m_pb, m_yduty, m_ya, m_yb);
        end
        checks++;
        if ({tx_load, tx_byte} !== {e_load, m_tx}) begin
          failures++;
          $display("FAIL rand_tx f%0d b%0d: got ld=%0d tx=%02h want ld=%0d tx=%02h", f, i, tx_load, tx_byte, e_load, m_tx);
        end
        checks++;
        if ({cnt_clear, cmd_err} !== {e_cc, e_err}) begin
          failures++;
          $display("FAIL rand_pulse f%0d b%0d: got cc=%0d err=%0d want cc=%0d err=%0d", f, i, cnt_clear, cmd_err, e_cc, e_err);
        end
        idle();
        checks++;
        if ({tx_load, cnt_clear, cmd_err} !== 4'b0000) begin
          failures++;
          $display("FAIL rand_pulse_width f%0d b%0d: got ld=%0d cc=%0d err=%0d want 0", f, i, tx_load, cnt_clear, cmd_err);
        end
      end
      drive($urandom_range(0, 3) == 0, 8'h13, 1, 16'h0, 16'h0);
      checks++;
      if ({cmd_err, cnt_clear, tx_load} !== {e_err, 3'b000}) begin
        failures++;
        $display("FAIL rand_frame_end f%0d: got err=%0d cc=%0d ld=%0d want err=%0d cc=0 ld=0", f, cmd_err, cnt_clear, tx_load, e_err);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] bytes[4];
    bytes = '{8'h11, 8'h02, 8'h00, 8'h80};
    for (int i = 0; i < 4; i++) drive(1, bytes[i], 0, 16'h0, 16'h0);
    checks++;
    if ({pitch_duty, pitch_dira, pitch_dirb} !== {10'h080, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL pre_async_set: got duty=%03h a=%0d b=%0d want 080 0 1", pitch_duty, pitch_dira, pitch_dirb);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pitch_duty, pitch_dira, pitch_dirb, tx_byte} !== '0) begin
      failures++;
      $display("FAIL async_reset: got duty=%03h a=%0d b=%0d tx=%02h want all 0 before clock edge", pitch_duty, pitch_dira, pitch_dirb, tx_byte);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_set_drive();
    test_get_count();
    test_clamp();
    test_abort();
    test_collision();
    test_global_reset();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
